config_chain_loader: RTL

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

---
 rtl/config_chain_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/config_chain_loader.sv
// Serial configuration chain loader: streams host words into a config shift
// chain (LOAD) or recirculates the chain to check its CRC against the last load (VERIFY).
module config_chain_loader #(
  parameter int CHAIN_LEN = 320,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              GSR,
  input  logic              cmd_start,
  input  logic              cmd_verify,
  input  logic              cmd_abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_in,
  output logic              cfg_en,
  input  logic              cfg_out,
  output logic              busy,
  output logic              done,
  output logic              crc_err,
  output logic [7:0]        crc_val
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    RECIRC,
    FINISH
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] buffer;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [7:0]        crc_acc;
  logic [7:0]        crc_nxt;
  logic              serial_bit;
  logic              is_load;

  // CRC-8 (0x07), one serial bit per call, MSB-first.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // One accumulator serves both operations: LOAD feeds it the outgoing bit,
  // VERIFY feeds it the bit coming back from the end of the chain.
  assign serial_bit = (state == SHIFT) ? buffer[0] : cfg_out;
  assign crc_nxt    = crc8_step(crc_acc, serial_bit);

  // NOTE: every output and next-state signal gets a default before the case so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    cfg_en     = 1'b0;
    cfg_in     = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (cmd_start) state_nxt = cmd_verify ? RECIRC : FETCH;
      end
      FETCH: begin
        word_ready = 1'b1;
        if (word_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        cfg_en = 1'b1;
        cfg_in = buffer[0];
        // Chain end wins over word end, which drops the unused top of the last word.
        if (bit_cnt == LAST_BIT)      state_nxt = FINISH;
        else if (bit_idx == LAST_IDX) state_nxt = FETCH;
      end
      RECIRC: begin
        cfg_en = 1'b1;
        cfg_in = cfg_out;
        if (bit_cnt == LAST_BIT) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (cmd_abort) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge GSR) begin
    if (GSR) begin
      state   <= IDLE;
      // NOTE: the word buffer is a plain register, not a memory, so it is reset
      // along with the control state at no real cost.
      buffer  <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
      crc_acc <= '0;
      crc_val <= '0;
      crc_err <= 1'b0;
      is_load <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!cmd_abort) begin
        case (state)
          IDLE: begin
            if (cmd_start) begin
              bit_cnt <= '0;
              bit_idx <= '0;
              crc_acc <= 8'h00;
              is_load <= ~cmd_verify;
              if (cmd_verify) crc_err <= 1'b0;
            end
          end
          FETCH: begin
            if (word_valid) begin
              buffer  <= word_in;
              bit_idx <= '0;
            end
          end
          SHIFT: begin
            buffer  <= buffer >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            bit_idx <= bit_idx + 1'b1;
            crc_acc <= crc_nxt;
          end
          RECIRC: begin
            bit_cnt <= bit_cnt + 1'b1;
            crc_acc <= crc_nxt;
            if (bit_cnt == LAST_BIT) crc_err <= (crc_nxt != crc_val);
          end
          FINISH: begin
            if (is_load) crc_val <= crc_acc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
